// File: rtl/mult_axil_pkg.sv
// Shared definitions for the AXI4-Lite multiplier peripheral: register map,
// CTRL bit positions, response codes and channel state encodings.
package mult_axil_pkg;

  localparam logic [1:0] REG_OPA    = 2'd0;
  localparam logic [1:0] REG_OPB    = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_DONE  = 2;
  localparam int CTRL_IE    = 3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [4:0] MULT_CYCLES = 5'd16;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  // Byte-strobed update of a 16-bit operand register.
  function automatic logic [15:0] merge_low_half(input logic [15:0] cur,
                                                 input logic [15:0] data,
                                                 input logic [1:0]  strb);
    logic [15:0] res;
    res = cur;
    if (strb[0]) res[7:0]  = data[7:0];
    if (strb[1]) res[15:8] = data[15:8];
    return res;
  endfunction

endpackage

// File: rtl/mult_shift_add.sv
// Unsigned 16x16 shift-add multiplier, one multiplier bit per cycle.
// A down-counter paces the 16 busy cycles; done pulses in the last one.
module mult_shift_add
  import mult_axil_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  logic [31:0] a_sh;
  logic [31:0] acc;
  logic [31:0] acc_next;
  logic [15:0] b_sh;
  logic [4:0]  cnt;

  assign acc_next = b_sh[0] ? acc + a_sh : acc;
  assign done     = busy && (cnt == 5'd1);

  // product only moves on completion, so it holds the previous result while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      product <= '0;
    end else if (busy) begin
      acc  <= acc_next;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt - 5'd1;
      if (done) begin
        busy    <= 1'b0;
        product <= acc_next;
      end
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= MULT_CYCLES;
      a_sh <= {16'h0000, a};
      b_sh <= b;
      acc  <= '0;
    end
  end

endmodule

// File: rtl/mult_axil_slave.sv
// AXI4-Lite slave wrapping a shift-add multiplier with OPA/OPB/CTRL/RESULT registers.
//   state   | meaning
//   WR_IDLE | waiting for AW and W valid together; accepts both in one cycle
//   WR_RESP | BVALID high, holding OKAY until BREADY
//   RD_IDLE | waiting for ARVALID; RDATA captured on acceptance
//   RD_RESP | RVALID high, RDATA held until RREADY
module mult_axil_slave
  import mult_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            IRQ
);

  wr_state_t   wr_state, wr_state_next;
  rd_state_t   rd_state, rd_state_next;
  logic        wr_hs, rd_hs;
  logic [1:0]  wr_idx, rd_idx;
  logic [15:0] opa_q, opb_q;
  logic        ie_q, done_q;
  logic [31:0] rdata_q, rd_word;
  logic        start_req;
  logic        mult_busy, mult_done;
  logic [31:0] mult_product;
  logic        unused_bits;

  assign wr_idx = S_AXI_AWADDR[3:2];
  assign rd_idx = S_AXI_ARADDR[3:2];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_state_next;
      rd_state <= rd_state_next;
    end
  end

  // Ready is combinational on the valids so acceptance lasts exactly one cycle.
  always_comb begin
    wr_state_next = wr_state;
    wr_hs         = 1'b0;
    case (wr_state)
      WR_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID && !ARESET) begin
        wr_hs         = 1'b1;
        wr_state_next = WR_RESP;
      end
      WR_RESP: if (S_AXI_BREADY) wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_next = rd_state;
    rd_hs         = 1'b0;
    case (rd_state)
      RD_IDLE: if (S_AXI_ARVALID && !ARESET) begin
        rd_hs         = 1'b1;
        rd_state_next = RD_RESP;
      end
      RD_RESP: if (S_AXI_RREADY) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  assign S_AXI_AWREADY = wr_hs;
  assign S_AXI_WREADY  = wr_hs;
  assign S_AXI_BVALID  = (wr_state == WR_RESP);
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = rd_hs;
  assign S_AXI_RVALID  = (rd_state == RD_RESP);
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = rdata_q;
  assign IRQ           = done_q && ie_q;

  assign start_req = wr_hs && (wr_idx == REG_CTRL) && S_AXI_WSTRB[0] &&
                     S_AXI_WDATA[CTRL_START] && !mult_busy;

  always_comb begin
    rd_word = '0;
    case (rd_idx)
      REG_OPA:    rd_word = {16'h0000, opa_q};
      REG_OPB:    rd_word = {16'h0000, opb_q};
      REG_CTRL:   rd_word = {28'h0, ie_q, done_q, mult_busy, 1'b0};
      REG_RESULT: rd_word = mult_product;
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      opa_q   <= '0;
      opb_q   <= '0;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (wr_hs) begin
        case (wr_idx)
          REG_OPA:  opa_q <= merge_low_half(opa_q, S_AXI_WDATA[15:0], S_AXI_WSTRB[1:0]);
          REG_OPB:  opb_q <= merge_low_half(opb_q, S_AXI_WDATA[15:0], S_AXI_WSTRB[1:0]);
          REG_CTRL: if (S_AXI_WSTRB[0]) ie_q <= S_AXI_WDATA[CTRL_IE];
          default:  ;
        endcase
      end
      if (start_req)      done_q <= 1'b0;
      else if (mult_done) done_q <= 1'b1;
      if (rd_hs) rdata_q <= rd_word;
    end
  end

  mult_shift_add u_mult (
    .clk     (ACLK),
    .rst     (ARESET),
    .start   (start_req),
    .a       (opa_q),
    .b       (opb_q),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (mult_product)
  );

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[1:0], S_AXI_WDATA[31:16], S_AXI_WSTRB[3:2]};

endmodule

// File: tb/tb_mult_axil_slave.sv
// Self-checking bench for mult_axil_slave: register vector table plus
// cycle-exact multiply, back-pressure, interrupt and reset sequences.
module tb_mult_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic        IRQ;

  localparam logic [3:0] A_OPA = 4'h0, A_OPB = 4'h4, A_CTRL = 4'h8, A_RES = 4'hC;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  mult_axil_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .IRQ(IRQ)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called and returns at #1 after a rising edge; hs_cyc is the edge count of acceptance.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int hs_cyc);
    logic ok;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY && S_AXI_WREADY) ok = 1'b1;
      @(posedge ACLK); #1;
      if (ok) break;
    end
    hs_cyc = cyc;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("write accepted", {31'b0, ok}, 32'd1);
    S_AXI_BREADY = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) begin
        ok = 1'b1;
        check("bresp", {30'b0, S_AXI_BRESP}, 32'd0);
      end
      @(posedge ACLK); #1;
      if (ok) break;
    end
    S_AXI_BREADY = 1'b0;
    check("bvalid seen", {31'b0, ok}, 32'd1);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output int waited);
    logic ok;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    ok = 1'b0; waited = 0; data = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY) ok = 1'b1; else waited++;
      @(posedge ACLK); #1;
      if (ok) break;
    end
    S_AXI_ARVALID = 1'b0;
    check("read accepted", {31'b0, ok}, 32'd1);
    S_AXI_RREADY = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_RVALID) begin
        ok = 1'b1;
        data = S_AXI_RDATA;
        check("rresp", {30'b0, S_AXI_RRESP}, 32'd0);
      end
      @(posedge ACLK); #1;
      if (ok) break;
    end
    S_AXI_RREADY = 1'b0;
    check("rvalid seen", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge ACLK); #1;
    end
  endtask

  // Issue a read whose address handshake lands on rising edge number 'target'.
  task automatic read_at(input logic [3:0] addr, input int target, output logic [31:0] data);
    int w;
    if (cyc > target - 1) begin
      n_errors++;
      $display("FAIL read_at schedule: cycle %0d already past %0d", cyc, target - 1);
    end
    wait_cyc(target - 1);
    axi_read(addr, data, w);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    int hs, w, n;

    vecs.push_back('{"opa full",        A_OPA,  32'h0000_1234, 4'b1111, A_OPA,  32'h0000_1234});
    vecs.push_back('{"opa byte0 strb",  A_OPA,  32'hAABB_CCDD, 4'b0001, A_OPA,  32'h0000_12DD});
    vecs.push_back('{"opa upper strb",  A_OPA,  32'hFFFF_FFFF, 4'b1100, A_OPA,  32'h0000_12DD});
    vecs.push_back('{"opb hi masked",   A_OPB,  32'hFFFF_5678, 4'b1111, A_OPB,  32'h0000_5678});
    vecs.push_back('{"opb byte1 strb",  A_OPB,  32'h0000_AB00, 4'b0010, A_OPB,  32'h0000_AB78});
    vecs.push_back('{"ctrl ie set",     A_CTRL, 32'h0000_0008, 4'b1111, A_CTRL, 32'h0000_0008});
    vecs.push_back('{"ctrl ro bits",    A_CTRL, 32'hFFFF_FFF6, 4'b1111, A_CTRL, 32'h0000_0000});
    vecs.push_back('{"ctrl strb zero",  A_CTRL, 32'h0000_0008, 4'b0000, A_CTRL, 32'h0000_0000});
    vecs.push_back('{"result ro",       A_RES,  32'hDEAD_BEEF, 4'b1111, A_RES,  32'h0000_0000});

    // reset with valids driven: nothing may be accepted
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("reset handshakes", {22'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                               S_AXI_RVALID, IRQ, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
    check("reset rdata", S_AXI_RDATA, 32'd0);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    ARESET = 1'b0;

    foreach (vecs[i]) begin
      axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, hs);
      axi_read(vecs[i].raddr, rd, w);
      check(vecs[i].name, rd, vecs[i].exp);
    end

    // 3 x 5: busy through edge N+16, result visible afterwards
    axi_write(A_OPA, 32'h3, 4'hF, hs);
    axi_write(A_OPB, 32'h5, 4'hF, hs);
    axi_write(A_CTRL, 32'h1, 4'hF, n);
    axi_read(A_CTRL, rd, w);
    check("3x5 busy early", rd, 32'h2);
    read_at(A_CTRL, n + 16, rd);
    check("3x5 busy last cycle", rd, 32'h2);
    axi_read(A_RES, rd, w);
    check("3x5 result", rd, 32'h0000_000F);

    // FFFF x FFFF: previous result during busy, done exactly after 16 cycles
    axi_write(A_OPA, 32'hFFFF_FFFF, 4'hF, hs);
    axi_read(A_OPA, rd, w);
    check("opa hi bits zero", rd, 32'h0000_FFFF);
    axi_write(A_OPB, 32'hFFFF_FFFF, 4'hF, hs);
    axi_write(A_CTRL, 32'h1, 4'hF, n);
    axi_read(A_RES, rd, w);
    check("result during busy", rd, 32'h0000_000F);
    read_at(A_CTRL, n + 17, rd);
    check("ffff done", rd, 32'h4);
    axi_read(A_RES, rd, w);
    check("ffff result", rd, 32'hFFFE_0001);

    // AW without W is not accepted; held B response blocks the next write
    S_AXI_AWADDR = A_OPA; S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("aw alone ready", {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd0);
      @(posedge ACLK); #1;
    end
    S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    check("aw+w ready", {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd3);
    @(posedge ACLK); #1;
    S_AXI_AWADDR = A_OPB; S_AXI_WDATA = 32'h99;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      check("bvalid held", {29'b0, S_AXI_BVALID, S_AXI_BRESP}, 32'h4);
      check("blocked write", {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd0);
      @(posedge ACLK); #1;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    check("bvalid before bready", {31'b0, S_AXI_BVALID}, 32'd1);
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    check("bvalid cleared", {31'b0, S_AXI_BVALID}, 32'd0);
    @(posedge ACLK); #1;
    axi_read(A_OPA, rd, w);
    check("opa after stall", rd, 32'h55);
    axi_read(A_OPB, rd, w);
    check("opb untouched", rd, 32'h0000_FFFF);

    // interrupt, ignored restart, DONE clear on new start
    axi_write(A_CTRL, 32'h8, 4'hF, hs);
    @(negedge ACLK);
    check("irq sticky done", {31'b0, IRQ}, 32'd1);
    @(posedge ACLK); #1;
    axi_write(A_OPA, 32'h2, 4'hF, hs);
    axi_write(A_OPB, 32'h3, 4'hF, hs);
    axi_write(A_CTRL, 32'h9, 4'hF, n);
    @(negedge ACLK);
    check("irq cleared by start", {31'b0, IRQ}, 32'd0);
    @(posedge ACLK); #1;
    axi_write(A_OPA, 32'h7, 4'hF, hs);
    axi_write(A_CTRL, 32'h9, 4'hF, hs);
    wait_cyc(n + 15);
    @(negedge ACLK);
    check("irq before done", {31'b0, IRQ}, 32'd0);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check("irq at done", {31'b0, IRQ}, 32'd1);
    @(posedge ACLK); #1;
    axi_read(A_RES, rd, w);
    check("2x3 result", rd, 32'h6);
    axi_read(A_CTRL, rd, w);
    check("ctrl done ie", rd, 32'hC);
    axi_write(A_CTRL, 32'h9, 4'hF, n);
    @(negedge ACLK);
    check("irq new start", {31'b0, IRQ}, 32'd0);
    @(posedge ACLK); #1;
    axi_read(A_CTRL, rd, w);
    check("ctrl busy ie", rd, 32'hA);
    wait_cyc(n + 18);
    axi_read(A_RES, rd, w);
    check("7x3 result", rd, 32'h15);

    // reset at busy cycle 8 with both responses pending
    axi_write(A_OPA, 32'hFF, 4'hF, hs);
    axi_write(A_OPB, 32'h101, 4'hF, hs);
    axi_write(A_CTRL, 32'h1, 4'hF, n);
    wait_cyc(n + 6);
    S_AXI_AWADDR = A_OPB; S_AXI_WDATA = 32'h1111; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = A_OPA; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    check("pending responses", {30'b0, S_AXI_BVALID, S_AXI_RVALID}, 32'd3);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check("mid-op reset outputs", {22'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                                   S_AXI_RVALID, IRQ, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
    check("mid-op reset rdata", S_AXI_RDATA, 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    axi_read(A_CTRL, rd, w);
    check("ctrl after reset", rd, 32'd0);
    check("first read latency", w, 32'd0);
    axi_read(A_RES, rd, w);
    check("result after reset", rd, 32'd0);
    axi_read(A_OPB, rd, w);
    check("opb after reset", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
